// File: rtl/mips_pkg.sv
// mips_pkg: shared multiply/divide encodings, FSM states and datapath width
package mips_pkg;
  localparam int WIDTH = 32;
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_t;
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: decode-side request/response bundle for the HI/LO unit
interface mult_div_unit_if;
  import mips_pkg::*;
  logic start;
  md_op_t op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic mthi;
  logic mtlo;
  logic busy;
  logic done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, rs_data, rt_data, mthi, mtlo, input busy, done, hi, lo);
  modport slave (input start, op, rs_data, rt_data, mthi, mtlo, output busy, done, hi, lo);
endinterface

// File: rtl/md_sign_fix.sv
// md_sign_fix: applies operand signs to the unsigned multiply/divide result
module md_sign_fix
  import mips_pkg::*;
(
  input  logic [2*WIDTH-1:0] raw,
  input  md_op_t             op,
  input  logic               neg_a,
  input  logic               neg_b,
  output logic [2*WIDTH-1:0] res
);
  logic [WIDTH-1:0] rem, quo;
  always_comb begin
    rem = neg_a ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
    quo = neg_a ^ neg_b ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
    res = op == MD_MULT && (neg_a ^ neg_b) ? -raw : op == MD_DIV ? {rem, quo} : raw;
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle shift-add multiply / restoring divide with HI/LO registers
module mult_div_unit
  import mips_pkg::*;
(
  input logic clk,
  input logic rst_n,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  md_state_t state;
  md_op_t op_r;
  logic [2*WIDTH-1:0] acc, fixed;
  logic [WIDTH-1:0] opnd, abs_a, abs_b;
  logic [CW-1:0] cnt;
  logic neg_a, neg_b, signed_op, is_div, dz, a_neg_in, b_neg_in;
  logic [WIDTH:0] mul_sum, div_trial;
  always_comb begin
    signed_op = bus.op == MD_MULT || bus.op == MD_DIV;
    is_div = bus.op == MD_DIV || bus.op == MD_DIVU;
    dz = is_div && bus.rt_data == '0;
    a_neg_in = signed_op & bus.rs_data[WIDTH-1];
    b_neg_in = signed_op & bus.rt_data[WIDTH-1];
    abs_a = a_neg_in ? -bus.rs_data : bus.rs_data;
    abs_b = b_neg_in ? -bus.rt_data : bus.rt_data;
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){acc[0]}} & {1'b0, opnd});
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
  end
  md_sign_fix u_fix (.raw(acc), .op(op_r), .neg_a(neg_a), .neg_b(neg_b), .res(fixed));
  // acc holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_r <= MD_MULT;
      acc <= '0;
      opnd <= '0;
      cnt <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            op_r <= bus.op;
            neg_a <= a_neg_in & ~dz;
            neg_b <= b_neg_in & ~dz;
            cnt <= CW'(WIDTH);
            opnd <= is_div ? abs_b : abs_a;
            acc <= dz ? {bus.rs_data, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
            bus.busy <= 1'b1;
            state <= dz ? FIX : is_div ? DIV : MUL;
          end else begin
            if (bus.mthi) bus.hi <= bus.rs_data;
            if (bus.mtlo) bus.lo <= bus.rs_data;
          end
        end
        MUL, DIV: begin
          acc <= state == MUL ? {mul_sum, acc[WIDTH-1:1]} :
                 div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} :
                 {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          {bus.hi, bus.lo} <= fixed;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with hand-computed HI/LO, latency and handshake checks
module tb_mult_div_unit;
  import mips_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  int lat, bc, dones;
  mult_div_unit_if bus();
  mult_div_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_op(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                       output int l, output int busy_cyc);
    @(negedge clk);
    bus.op = o;
    bus.rs_data = a;
    bus.rt_data = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    l = 0;
    busy_cyc = 0;
    while (!bus.done && l < 100) begin
      if (bus.busy) busy_cyc++;
      @(posedge clk);
      #1 l++;
    end
  endtask

  task automatic chk_op(input string tag, input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int elat);
    int l, bcy;
    do_op(o, a, b, l, bcy);
    check({tag, " hi"}, 64'(bus.hi), 64'(eh));
    check({tag, " lo"}, 64'(bus.lo), 64'(el));
    check({tag, " latency"}, 64'(l), 64'(elat));
    check({tag, " busy cycles"}, 64'(bcy), 64'(elat));
    check({tag, " busy low"}, 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1 check({tag, " done falls"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = MD_MULT;
    bus.rs_data = '0;
    bus.rt_data = '0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    chk_op("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    chk_op("mult -3*7", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
    chk_op("divu 7/2", MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 33);
    chk_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    chk_op("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    chk_op("div 100/-7", MD_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 33);
    chk_op("divu 5/0", MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
    chk_op("div -5/0", MD_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);

    // moves: one cycle each, then both together
    @(negedge clk);
    bus.rs_data = 32'h1234_5678;
    bus.mthi = 1'b1;
    @(negedge clk);
    check("mthi hi", 64'(bus.hi), 64'h1234_5678);
    check("mthi lo kept", 64'(bus.lo), 64'hFFFF_FFFF);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b1;
    bus.rs_data = 32'h9ABC_DEF0;
    @(negedge clk);
    check("mtlo lo", 64'(bus.lo), 64'h9ABC_DEF0);
    check("mtlo hi kept", 64'(bus.hi), 64'h1234_5678);
    bus.mthi = 1'b1;
    bus.rs_data = 32'h55AA_55AA;
    @(negedge clk);
    check("mthi+mtlo hi", 64'(bus.hi), 64'h55AA_55AA);
    check("mthi+mtlo lo", 64'(bus.lo), 64'h55AA_55AA);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;

    // start with a move in IDLE: start wins, move dropped, then start/mthi held while busy
    bus.op = MD_MULTU;
    bus.rs_data = 32'd2;
    bus.rt_data = 32'd3;
    bus.start = 1'b1;
    bus.mthi = 1'b1;
    @(posedge clk);
    #1 bus.rs_data = 32'hDEAD_BEEF;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (i == 10) check("hi stale while busy", 64'(bus.hi), 64'h55AA_55AA);
    end
    bus.start = 1'b0;
    bus.mthi = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("held start dones", 64'(dones), 64'd1);
    check("held start hi", 64'(bus.hi), 64'd0);
    check("held start lo", 64'(bus.lo), 64'd6);

    // reset mid-operation
    @(negedge clk);
    bus.op = MD_MULT;
    bus.rs_data = 32'd5;
    bus.rt_data = 32'd6;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort hi", 64'(bus.hi), 64'd0);
    check("abort lo", 64'(bus.lo), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort no done", 64'(dones), 64'd0);
    chk_op("mult after rst", MD_MULT, 32'd5, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFE2, 33);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
